// File: rtl/sprite_ram_mp.sv
// rtl/sprite_ram_mp.sv - multi-read-port sprite attribute RAM with lane enables and clear engine
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous active-high reset; restarts the clear engine
//   clear_req    one-cycle request to fill every entry with CLEAR_VALUE
//   clear_busy   high while the clear engine owns the array
//   we1          write enable
//   write_addr1  write address
//   data1        write data
//   be1          per-lane write enables, bit i covers data1[i*LANE_WIDTH +: LANE_WIDTH]
//   write_drop   one-cycle pulse after a write was discarded during a clear
//   re           per-port read enable
//   read_addr    packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   q            packed registered read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   q_valid      per-port valid, registered alongside q
module sprite_ram_mp #(
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    ADDR_WIDTH  = 6,
   parameter int                    NUM_RD      = 2,
   parameter int                    LANE_WIDTH  = 8,
   parameter bit                    RDW_NEW     = 1'b0,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           clear_req,
   output logic                           clear_busy,
   input  logic                           we1,
   input  logic [ADDR_WIDTH-1:0]          write_addr1,
   input  logic [DATA_WIDTH-1:0]          data1,
   input  logic [DATA_WIDTH/LANE_WIDTH-1:0] be1,
   output logic                           write_drop,
   input  logic [NUM_RD-1:0]              re,
   input  logic [NUM_RD*ADDR_WIDTH-1:0]   read_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0]   q,
   output logic [NUM_RD-1:0]              q_valid
);

   localparam int LANES = DATA_WIDTH / LANE_WIDTH;
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t                state;
   state_t                state_nxt;
   // One extra bit so the counter never wraps back into the array range.
   logic [ADDR_WIDTH:0]   clr_addr;
   logic [ADDR_WIDTH:0]   clr_addr_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_CLEAR;
         clr_addr <= '0;
      end else begin
         state    <= state_nxt;
         clr_addr <= clr_addr_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      clr_addr_nxt = clr_addr;
      case (state)
         ST_IDLE: begin
            if (clear_req) begin
               state_nxt    = ST_CLEAR;
               clr_addr_nxt = '0;
            end
         end
         ST_CLEAR: begin
            // clear_req is deliberately ignored here: a clear never restarts or extends.
            clr_addr_nxt = clr_addr + (ADDR_WIDTH + 1)'(1);
            if (clr_addr == CLR_LAST) begin
               state_nxt = ST_IDLE;
            end
         end
      endcase
   end

   assign clear_busy = (state == ST_CLEAR);

   logic in_idle;
   logic clearing;
   assign in_idle  = !reset && (state == ST_IDLE);
   assign clearing = !reset && (state == ST_CLEAR);

   // Shared write port: the clear engine takes priority over we1.
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [LANES-1:0]      wr_be;

   always_comb begin
      wr_en   = clearing || (in_idle && we1);
      wr_addr = write_addr1;
      wr_data = data1;
      wr_be   = be1;
      if (clearing) begin
         wr_addr = clr_addr[ADDR_WIDTH-1:0];
         wr_data = CLEAR_VALUE;
         wr_be   = '1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         write_drop <= 1'b0;
      end else begin
         write_drop <= we1 && (state == ST_CLEAR);
      end
   end

   // Each read port owns a private bank (one simple dual-port RAM per lane),
   // all banks written in parallel so they hold identical contents.
   for (genvar k = 0; k < NUM_RD; k++) begin : g_port
      logic [ADDR_WIDTH-1:0] raddr;
      logic                  rd_fire;
      logic                  rdw_hit;
      logic                  v;

      assign raddr   = read_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign rd_fire = in_idle && re[k];
      assign rdw_hit = in_idle && we1 && (raddr == write_addr1);

      always_ff @(posedge clk) begin
         if (reset) begin
            v <= 1'b0;
         end else begin
            v <= rd_fire;
         end
      end
      assign q_valid[k] = v;

      for (genvar l = 0; l < LANES; l++) begin : g_lane
         logic [LANE_WIDTH-1:0] mem [DEPTH];
         logic [LANE_WIDTH-1:0] q_lane;

         always_ff @(posedge clk) begin
            if (wr_en && wr_be[l]) begin
               mem[wr_addr] <= wr_data[l*LANE_WIDTH +: LANE_WIDTH];
            end
         end

         // The array read is always read-first; new-data behaviour is a
         // bypass mux on the output register so the array stays inferable.
         always_ff @(posedge clk) begin
            if (reset) begin
               q_lane <= '0;
            end else if (rd_fire) begin
               if (RDW_NEW && rdw_hit && be1[l]) begin
                  q_lane <= data1[l*LANE_WIDTH +: LANE_WIDTH];
               end else begin
                  q_lane <= mem[raddr];
               end
            end
         end

         assign q[k*DATA_WIDTH + l*LANE_WIDTH +: LANE_WIDTH] = q_lane;
      end
   end

endmodule

// File: tb/tb_sprite_ram_mp.sv
// tb/tb_sprite_ram_mp.sv - scoreboard bench for sprite_ram_mp, old-data and new-data variants side by side
module tb_sprite_ram_mp;

   localparam int DW = 16;
   localparam int AW = 6;
   localparam int NR = 2;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             clear_req = 1'b0;
   logic             we1 = 1'b0;
   logic [AW-1:0]    write_addr1 = '0;
   logic [DW-1:0]    data1 = '0;
   logic [1:0]       be1 = '0;
   logic [NR-1:0]    re = '0;
   logic [NR*AW-1:0] read_addr = '0;

   logic             busy_a, busy_b, drop_a, drop_b;
   logic [NR*DW-1:0] q_a, q_b;
   logic [NR-1:0]    qv_a, qv_b;

   int checks = 0;
   int failures = 0;
   int cyc_cnt = 0;
   int s;
   int n;

   typedef struct {
      logic [15:0] d_old;
      logic [15:0] d_new;
   } exp_t;

   exp_t sb0[$];
   exp_t sb1[$];

   sprite_ram_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .LANE_WIDTH(8), .RDW_NEW(1'b0))
   dut_old (
      .clk(clk), .reset(reset), .clear_req(clear_req), .clear_busy(busy_a),
      .we1(we1), .write_addr1(write_addr1), .data1(data1), .be1(be1), .write_drop(drop_a),
      .re(re), .read_addr(read_addr), .q(q_a), .q_valid(qv_a)
   );

   sprite_ram_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .LANE_WIDTH(8), .RDW_NEW(1'b1))
   dut_new (
      .clk(clk), .reset(reset), .clear_req(clear_req), .clear_busy(busy_b),
      .we1(we1), .write_addr1(write_addr1), .data1(data1), .be1(be1), .write_drop(drop_b),
      .re(re), .read_addr(read_addr), .q(q_b), .q_valid(qv_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int k, input logic [15:0] o, input logic [15:0] nw);
      exp_t e;
      e.d_old = o;
      e.d_new = nw;
      if (k == 0) sb0.push_back(e);
      else        sb1.push_back(e);
   endtask

   task automatic rd(input int k, input logic [5:0] a, input logic [15:0] o, input logic [15:0] nw);
      re[k] = 1'b1;
      read_addr[k*AW +: AW] = a;
      push(k, o, nw);
   endtask

   task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic [1:0] b);
      we1 = 1'b1;
      write_addr1 = a;
      data1 = d;
      be1 = b;
   endtask

   task automatic idle();
      we1 = 1'b0;
      re = '0;
      clear_req = 1'b0;
   endtask

   task automatic wait_clear_done(input string name);
      while ((busy_a || busy_b) && (cyc_cnt - s) < 200) step();
      chk(name, 64'(cyc_cnt - s), 64'd64);
   endtask

   // Monitor: pop one expectation per valid read and compare both variants.
   always @(negedge clk) begin
      if (!reset) begin
         for (int k = 0; k < NR; k++) begin
            if (qv_a[k] || qv_b[k]) begin
               exp_t e;
               if ((k == 0 && sb0.size() == 0) || (k == 1 && sb1.size() == 0)) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_read port=%0d qv_old=%b qv_new=%b expected=none", k, qv_a[k], qv_b[k]);
               end else begin
                  if (k == 0) e = sb0.pop_front();
                  else        e = sb1.pop_front();
                  chk($sformatf("qv_old_p%0d", k), 64'(qv_a[k]), 64'd1);
                  chk($sformatf("qv_new_p%0d", k), 64'(qv_b[k]), 64'd1);
                  chk($sformatf("q_old_p%0d", k), 64'(q_a[k*DW +: DW]), 64'(e.d_old));
                  chk($sformatf("q_new_p%0d", k), 64'(q_b[k*DW +: DW]), 64'(e.d_new));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      // Reset state
      reset = 1'b1;
      repeat (3) step();
      chk("rst_busy", {busy_a, busy_b}, 2'b11);
      chk("rst_qv", {qv_a, qv_b}, 4'b0000);
      chk("rst_q", {q_a, q_b}, 64'd0);
      chk("rst_drop", {drop_a, drop_b}, 2'b00);

      // 1: boot clear lasts exactly 64 cycles, then reads return zero
      reset = 1'b0;
      s = cyc_cnt;
      wait_clear_done("boot_clear_len");
      rd(0, 6'd0, 16'h0000, 16'h0000);
      rd(1, 6'd31, 16'h0000, 16'h0000);
      step();
      chk("lat_t1", {qv_a, qv_b}, 4'b1111);
      idle();
      rd(0, 6'd63, 16'h0000, 16'h0000);
      step();
      idle();

      // 2: write then dual-port read of the same entry
      wr(6'd5, 16'h00A5, 2'b11);
      step();
      idle();
      rd(0, 6'd5, 16'h00A5, 16'h00A5);
      rd(1, 6'd5, 16'h00A5, 16'h00A5);
      step();
      chk("lat_t2", {qv_a, qv_b}, 4'b1111);
      idle();

      // 3: read-during-write with upper lane only
      wr(6'd9, 16'h1234, 2'b11);
      step();
      idle();
      wr(6'd9, 16'hABCD, 2'b10);
      rd(0, 6'd9, 16'h1234, 16'hAB34);
      step();
      idle();
      rd(0, 6'd9, 16'hAB34, 16'hAB34);
      step();
      idle();
      // be1 = 0 is a no-op, also during a same-address read
      wr(6'd9, 16'hFFFF, 2'b00);
      rd(1, 6'd9, 16'hAB34, 16'hAB34);
      step();
      idle();
      // lower lane only
      wr(6'd9, 16'h5566, 2'b01);
      step();
      idle();
      rd(0, 6'd9, 16'hAB66, 16'hAB66);
      step();
      idle();

      // 4: fill pattern, clear, dropped write, reads during clear
      for (int a = 0; a < 64; a++) begin
         wr(6'(a), 16'(a ^ 8'h5A), 2'b11);
         step();
      end
      idle();
      rd(0, 6'd0, 16'h005A, 16'h005A);
      rd(1, 6'd17, 16'h004B, 16'h004B);
      step();
      idle();
      rd(0, 6'd63, 16'h0065, 16'h0065);
      step();
      idle();
      clear_req = 1'b1;
      step();
      s = cyc_cnt;
      clear_req = 1'b0;
      chk("clr_busy_start", {busy_a, busy_b}, 2'b11);
      step();
      wr(6'd3, 16'hFFFF, 2'b11);
      re = 2'b11;
      read_addr = {6'd3, 6'd3};
      step();
      chk("drop_pulse", {drop_a, drop_b}, 2'b11);
      chk("clr_rd_invalid", {qv_a, qv_b}, 4'b0000);
      idle();
      step();
      chk("drop_single", {drop_a, drop_b}, 2'b00);
      while ((busy_a || busy_b) && (cyc_cnt - s) < 200) begin
         re = ((cyc_cnt - s) == 63) ? 2'b11 : 2'b00;
         step();
      end
      re = '0;
      chk("clear_len", 64'(cyc_cnt - s), 64'd64);
      chk("last_clr_rd", {qv_a, qv_b}, 4'b0000);
      for (int a = 0; a < 64; a++) begin
         rd(0, 6'(a), 16'h0000, 16'h0000);
         rd(1, 6'(63 - a), 16'h0000, 16'h0000);
         step();
      end
      idle();

      // 5: reset mid-clear restarts a full clear; no drop pulse under reset
      for (int a = 0; a < 64; a++) begin
         wr(6'(a), 16'(a ^ 8'h5A), 2'b11);
         step();
      end
      idle();
      clear_req = 1'b1;
      step();
      s = cyc_cnt;
      clear_req = 1'b0;
      while ((cyc_cnt - s) < 20) step();
      reset = 1'b1;
      wr(6'd7, 16'hFFFF, 2'b11);
      step();
      chk("rst_mid_busy", {busy_a, busy_b}, 2'b11);
      step();
      chk("rst_no_drop", {drop_a, drop_b}, 2'b00);
      reset = 1'b0;
      idle();
      s = cyc_cnt;
      wait_clear_done("restart_clear_len");
      for (int a = 0; a < 64; a++) begin
         rd(0, 6'(a), 16'h0000, 16'h0000);
         step();
      end
      idle();

      // 6: clear_req during a clear does not extend it
      clear_req = 1'b1;
      step();
      s = cyc_cnt;
      clear_req = 1'b0;
      while ((busy_a || busy_b) && (cyc_cnt - s) < 200) begin
         clear_req = ((cyc_cnt - s) == 40);
         step();
      end
      clear_req = 1'b0;
      chk("no_extend_len", 64'(cyc_cnt - s), 64'd64);
      wr(6'd12, 16'hBEEF, 2'b11);
      step();
      idle();
      rd(0, 6'd12, 16'hBEEF, 16'hBEEF);
      rd(1, 6'd12, 16'hBEEF, 16'hBEEF);
      step();
      idle();

      repeat (3) step();
      chk("sb_empty", 64'(sb0.size() + sb1.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sprite_ram_mp.md
Name: sprite_ram_mp

Overview:
- Parametrised successor to the sprite attribute RAM: one write port and NUM_RD registered read ports.
- Adds per-lane write enables, selectable read-during-write behaviour, and a hardware clear engine that fills every entry with CLEAR_VALUE after reset or on request.
- Sits between the sprite-table writer (CPU/DMA side) and the sprite renderer's parallel fetch units.

Parameters:
DATA_WIDTH, 8, bits per entry; must be a multiple of LANE_WIDTH
ADDR_WIDTH, 6, address bits; DEPTH = 2**ADDR_WIDTH
NUM_RD, 2, number of independent read ports (1..4)
LANE_WIDTH, 8, bits per write-enable lane; LANES = DATA_WIDTH/LANE_WIDTH
RDW_NEW, 0, same-address read during write: 0 returns old data, 1 returns merged new data
CLEAR_VALUE, 0, value written to every entry by the clear engine

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
clear_req  in  1  one-cycle request to start a full clear
clear_busy  out  1  high while the clear engine owns the array
we1  in  1  write enable
write_addr1  in  ADDR_WIDTH  write address
data1  in  DATA_WIDTH  write data
be1  in  LANES  lane enables; bit i covers data1[i*LANE_WIDTH +: LANE_WIDTH]
write_drop  out  1  one-cycle pulse: a we1 write was discarded because the clear engine was busy
re  in  NUM_RD  per-port read enable
read_addr  in  NUM_RD*ADDR_WIDTH  packed read addresses; port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
q  out  NUM_RD*DATA_WIDTH  packed registered read data; port k at [k*DATA_WIDTH +: DATA_WIDTH]
q_valid  out  NUM_RD  per-port valid, registered alongside q

Behaviour:
- Reset values (while reset is high):
  - q = 0, q_valid = 0, write_drop = 0.
  - FSM = CLEAR, clr_addr = 0, clear_busy = 1.
  - Array contents are not written while reset is high.
- FSM states:
  - IDLE: clear_busy = 0. clear_req = 1 moves to CLEAR next cycle with clr_addr = 0.
  - CLEAR: clear_busy = 1. Each cycle writes CLEAR_VALUE to ram[clr_addr] (all lanes) and increments clr_addr. After the cycle that writes DEPTH-1, the FSM returns to IDLE.
- Clear timing:
  - A clear takes exactly DEPTH cycles after reset release, or after the clear_req cycle.
  - clr_addr is ADDR_WIDTH+1 bits wide; there is no wrap-around.
- clear_req during CLEAR is ignored; the clear neither restarts nor extends.
- Reset asserted mid-clear restarts the clear from entry 0 after reset releases.
- Write port, IDLE:
  - we1 = 1 updates only the lanes whose be1 bit is set; other lanes keep their contents.
  - be1 = 0 with we1 = 1 is a legal no-op.
- Write port, CLEAR (and while reset is high): the write is discarded. write_drop pulses the following cycle, except that no pulse is generated while reset is high.
- Read ports:
  - Latency is 1 cycle. If re[k] = 1 and the FSM is IDLE, then next cycle q[k] = ram[read_addr[k]] and q_valid[k] = 1.
  - If re[k] = 0, or the FSM is CLEAR, then next cycle q_valid[k] = 0 and q[k] holds its previous value.
  - A read issued on the cycle the FSM transitions CLEAR→IDLE (last clear write) is treated as CLEAR: not valid.
- Read-during-write, same cycle, read_addr[k] == write_addr1, we1 = 1, IDLE:
  - RDW_NEW = 0: q[k] = pre-write contents.
  - RDW_NEW = 1: q[k] = written lanes from data1, unwritten lanes from old contents.
- Multiple read ports may address the same entry in the same cycle; all receive identical data.
- Ports are independent; there are no priority or arbitration effects between read ports.
- The array must be inferable as RAM. A port that cannot map directly to a block RAM read port is built from replicated banks written in parallel.

Test Plan:
1. Release reset, idle → clear_busy stays high for exactly 64 cycles then falls; reads of addresses 0, 31 and 63 return 0x00 with q_valid = 1, one cycle after re.
2. IDLE; write 0xA5 to addr 5; next cycle port0 reads addr 5 and port1 reads addr 5 → both q = 0xA5, q_valid = 2'b11.
3. DATA_WIDTH = 16, entry 9 = 0x1234; write data 0xABCD, be1 = 2'b10 to addr 9 while port0 reads addr 9 → RDW_NEW = 0: q0 = 0x1234; RDW_NEW = 1: q0 = 0xAB34; next-cycle read = 0xAB34.
4. Fill addr 0..63 with pattern addr^0x5A, pulse clear_req; we1 to addr 3 two cycles later → write_drop pulses; reads during clear give q_valid = 0; after 64 cycles all entries read 0x00.
5. Start a clear, assert reset at clr_addr = 20 for 2 cycles → after release clear_busy is high for a full 64 cycles; entries 0..63 all read CLEAR_VALUE.
6. clear_req pulsed again at clr_addr = 40 → busy ends at the original 64-cycle point; no extension.
